// File: rtl/gray_codec_pipe_if.sv
// Handshake bundle for gray_codec_pipe: producer side (in_*) and consumer side (out_*).
interface gray_codec_pipe_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipeline computing bin->gray, gray->bin or gray increment.
// S1 holds the raw operand and mode; S2 holds the result presented to the consumer.
module gray_codec_pipe #(
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_codec_pipe_if.slave  bus
);
    localparam logic [1:0] MODE_B2G = 2'b00;
    localparam logic [1:0] MODE_G2B = 2'b01;
    localparam logic [1:0] MODE_INC = 2'b10;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic [1:0]       s1_mode_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_err_q;

    logic             in_fire;
    logic             out_fire;
    logic             s2_load;
    logic [WIDTH-1:0] res_d;
    logic             err_d;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // in_ready depends only on state and out_ready, never on in_valid.
    assign bus.in_ready  = !s1_valid_q || !s2_valid_q || bus.out_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_err   = s2_err_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid_q && bus.out_ready;
    assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);

    always_comb begin
        res_d = s1_data_q;
        err_d = 1'b0;
        case (s1_mode_q)
            MODE_B2G: res_d = bin2gray(s1_data_q);
            MODE_G2B: res_d = gray2bin(s1_data_q);
            MODE_INC: res_d = bin2gray(gray2bin(s1_data_q) + WIDTH'(1));
            default:  err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= bus.in_data;
                s1_mode_q  <= bus.in_mode;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end

            if (s2_load) begin
                s2_valid_q <= 1'b1;
                s2_data_q  <= res_d;
                s2_err_q   <= err_d;
            end else if (out_fire) begin
                s2_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe at WIDTH 5, 2 and 16; expectations come from an arithmetic Gray model.
module tb_gray_codec_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gray_codec_pipe_if #(.WIDTH(5))  b5 ();
    gray_codec_pipe_if #(.WIDTH(2))  b2 ();
    gray_codec_pipe_if #(.WIDTH(16)) b16 ();

    gray_codec_pipe #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(b5));
    gray_codec_pipe #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    gray_codec_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    function automatic logic [15:0] wmask(input int w);
        logic [16:0] m;
        m = (17'd1 << w) - 17'd1;
        return m[15:0];
    endfunction

    // Returns {err, data} for a w-bit operand.
    function automatic logic [16:0] ref_op(input logic [15:0] din, input logic [1:0] mode, input int w);
        logic [15:0] d;
        logic [15:0] b;
        logic [16:0] r;
        d = din & wmask(w);
        b = '0;
        r = {1'b1, d};
        if (mode != 2'd3) begin
            if (mode == 2'd0) begin
                r = {1'b0, d ^ (d >> 1)};
            end else begin
                for (int s = 0; s < w; s++) b = b ^ (d >> s);
                if (mode == 2'd1) begin
                    r = {1'b0, b};
                end else begin
                    b = (b + 16'd1) & wmask(w);
                    r = {1'b0, b ^ (b >> 1)};
                end
            end
        end
        return r;
    endfunction

    task automatic idle_all();
        b5.in_valid  = 1'b0; b5.in_data  = '0; b5.in_mode  = '0; b5.out_ready  = 1'b1;
        b2.in_valid  = 1'b0; b2.in_data  = '0; b2.in_mode  = '0; b2.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_mode = '0; b16.out_ready = 1'b1;
    endtask

    // One cycle on the WIDTH=5 instance; entered and left just after a falling edge.
    task automatic cyc5(input logic v, input logic [4:0] d, input logic [1:0] m, input logic r,
                        output logic acc, output logic fire, output logic rdy,
                        output logic ov, output logic [4:0] od, output logic oe);
        b5.in_valid  = v;
        b5.in_data   = d;
        b5.in_mode   = m;
        b5.out_ready = r;
        #1;
        rdy  = b5.in_ready;
        ov   = b5.out_valid;
        od   = b5.out_data;
        oe   = b5.out_err;
        acc  = v && rdy;
        fire = ov && r;
        @(negedge clk);
    endtask

    task automatic stream5(input logic [6:0] words[$], output logic [5:0] res[$]);
        int sent = 0;
        int cyc  = 0;
        logic acc, fire, rdy, ov, oe;
        logic [4:0] od;
        logic [6:0] w;
        res = {};
        while (res.size() < words.size() && cyc < 500) begin
            w = (sent < words.size()) ? words[sent] : 7'd0;
            cyc5(sent < words.size(), w[4:0], w[6:5], 1'b1, acc, fire, rdy, ov, od, oe);
            if (acc) sent++;
            if (fire) res.push_back({oe, od});
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic acc, fire, rdy, ov, oe;
        logic [4:0] od;
        idle_all();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", b5.out_valid); end
        checks++; if (b5.out_data !== 5'd0) begin errors++; $display("FAIL rst_out_data got=%b exp=00000", b5.out_data); end
        checks++; if (b5.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", b5.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc5(1'b1, 5'b10011, 2'd0, 1'b0, acc, fire, rdy, ov, od, oe);
        cyc5(1'b1, 5'b00101, 2'd3, 1'b0, acc, fire, rdy, ov, od, oe);
        #1;
        checks++; if (b5.out_valid !== 1'b1 || b5.in_ready !== 1'b0) begin
            errors++; $display("FAIL midstream_full got valid=%b ready=%b exp valid=1 ready=0", b5.out_valid, b5.in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", b5.out_valid); end
        checks++; if (b5.out_data !== 5'd0 || b5.out_err !== 1'b0) begin
            errors++; $display("FAIL async_rst_data got=%b/%b exp=00000/0", b5.out_data, b5.out_err);
        end
        checks++; if (b5.in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", b5.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc5(1'b0, 5'd0, 2'd0, 1'b1, acc, fire, rdy, ov, od, oe);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL stale_after_rst[%0d] got=%b exp=0", i, ov); end
        end
    endtask

    task automatic test_basic();
        logic [1:0] tm[6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [4:0] td[6] = '{5'b10110, 5'b11101, 5'b01010, 5'b11101, 5'b10000, 5'b00000};
        logic [4:0] te[6] = '{5'b11101, 5'b10110, 5'b01010, 5'b11100, 5'b00000, 5'b00001};
        logic       tr[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic acc, fire, rdy, ov, oe;
        logic [4:0] od;
        for (int i = 0; i < 6; i++) begin
            cyc5(1'b1, td[i], tm[i], 1'b1, acc, fire, rdy, ov, od, oe);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept[%0d] got=%b exp=1", i, acc); end
            cyc5(1'b0, 5'd0, 2'd0, 1'b1, acc, fire, rdy, ov, od, oe);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d] got=%b exp=0", i, ov); end
            cyc5(1'b0, 5'd0, 2'd0, 1'b1, acc, fire, rdy, ov, od, oe);
            checks++; if (ov !== 1'b1 || od !== te[i] || oe !== tr[i]) begin
                errors++; $display("FAIL basic_result[%0d] got v=%b d=%b e=%b exp v=1 d=%b e=%b", i, ov, od, oe, te[i], tr[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [6:0] words[$];
        logic [5:0] res[$];
        logic [5:0] back[$];
        logic [16:0] e;
        words = {};
        for (int i = 0; i < 32; i++) words.push_back({2'd0, 5'(i)});
        stream5(words, res);
        checks++; if (res.size() != 32) begin
            errors++; $display("FAIL roundtrip_fwd_count got=%0d exp=32", res.size());
            return;
        end
        for (int i = 0; i < 32; i++) begin
            e = ref_op(16'(i), 2'd0, 5);
            checks++; if (res[i] !== {1'b0, e[4:0]}) begin
                errors++; $display("FAIL b2g[%0d] got=%b exp=%b", i, res[i], {1'b0, e[4:0]});
            end
            if (i > 0) begin
                checks++; if ($countones(res[i][4:0] ^ res[i-1][4:0]) != 1) begin
                    errors++; $display("FAIL b2g_one_bit[%0d] got=%b prev=%b exp one bit apart", i, res[i][4:0], res[i-1][4:0]);
                end
            end
        end
        words = {};
        for (int i = 0; i < 32; i++) words.push_back({2'd1, res[i][4:0]});
        stream5(words, back);
        checks++; if (back.size() != 32) begin
            errors++; $display("FAIL roundtrip_back_count got=%0d exp=32", back.size());
            return;
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (back[i] !== {1'b0, 5'(i)}) begin
                errors++; $display("FAIL g2b_back[%0d] got=%b exp=%b", i, back[i], {1'b0, 5'(i)});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] wd[5] = '{5'b01101, 5'b11111, 5'b10000, 5'b00111, 5'b10101};
        logic [1:0] wm[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [5:0] got[$];
        logic [16:0] e;
        logic [4:0] held;
        logic [4:0] d;
        logic [1:0] m;
        logic acc, fire, rdy, ov, oe;
        logic [4:0] od;
        int sent = 0;
        int cyc  = 0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
            d = (sent < 5) ? wd[sent] : 5'd0;
            m = (sent < 5) ? wm[sent] : 2'd0;
            cyc5(sent < 5, d, m, 1'b0, acc, fire, rdy, ov, od, oe);
            if (acc) sent++;
            if (c >= 2) begin
                checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, rdy); end
            end
            if (c == 2) held = od;
            if (c == 3) begin
                checks++; if (od !== held) begin errors++; $display("FAIL bp_stable got=%b exp=%b", od, held); end
            end
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", sent); end
        got = {};
        while (got.size() < 5 && cyc < 50) begin
            d = (sent < 5) ? wd[sent] : 5'd0;
            m = (sent < 5) ? wm[sent] : 2'd0;
            cyc5(sent < 5, d, m, 1'b1, acc, fire, rdy, ov, od, oe);
            if (acc) sent++;
            if (fire) got.push_back({oe, od});
            cyc++;
        end
        checks++; if (got.size() != 5) begin
            errors++; $display("FAIL bp_drain_count got=%0d exp=5", got.size());
            return;
        end
        for (int i = 0; i < 5; i++) begin
            e = ref_op(16'(wd[i]), wm[i], 5);
            checks++; if (got[i] !== {e[16], e[4:0]}) begin
                errors++; $display("FAIL bp_order[%0d] got=%b exp=%b", i, got[i], {e[16], e[4:0]});
            end
        end
    endtask

    // Same handshake pattern on all three widths, independent random operands.
    task automatic test_random();
        logic [50:0] q[$];
        logic [50:0] exp_all;
        logic [16:0] a5, a2, a16, h5, h2, h16;
        logic [15:0] d5, d2, d16;
        logic [1:0]  m5, m2, m16;
        logic v, r, stall_prev;
        int acc_n = 0;
        int cyc   = 0;
        stall_prev = 1'b0;
        h5 = '0; h2 = '0; h16 = '0;
        while ((acc_n < 1000 || q.size() != 0) && cyc < 20000) begin
            v   = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2) != 0);
            d5  = 16'($urandom) & wmask(5);  m5  = 2'($urandom_range(0, 3));
            d2  = 16'($urandom) & wmask(2);  m2  = 2'($urandom_range(0, 3));
            d16 = 16'($urandom);             m16 = 2'($urandom_range(0, 3));
            b5.in_valid  = v; b5.in_data  = d5[4:0]; b5.in_mode  = m5;  b5.out_ready  = r;
            b2.in_valid  = v; b2.in_data  = d2[1:0]; b2.in_mode  = m2;  b2.out_ready  = r;
            b16.in_valid = v; b16.in_data = d16;     b16.in_mode = m16; b16.out_ready = r;
            #1;
            a5  = {b5.out_err, 11'd0, b5.out_data};
            a2  = {b2.out_err, 14'd0, b2.out_data};
            a16 = {b16.out_err, b16.out_data};
            if (stall_prev) begin
                checks++; if (a5 !== h5 || a2 !== h2 || a16 !== h16) begin
                    errors++; $display("FAIL rnd_stall_hold cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, a5, a2, a16, h5, h2, h16);
                end
            end
            checks++; if (b2.in_ready !== b5.in_ready || b16.in_ready !== b5.in_ready ||
                          b2.out_valid !== b5.out_valid || b16.out_valid !== b5.out_valid) begin
                errors++; $display("FAIL rnd_lockstep cyc=%0d got rdy=%b%b%b val=%b%b%b exp all equal", cyc,
                                   b5.in_ready, b2.in_ready, b16.in_ready, b5.out_valid, b2.out_valid, b16.out_valid);
            end
            if (v && b5.in_ready) begin
                q.push_back({ref_op(d16, m16, 16), ref_op(d2, m2, 2), ref_op(d5, m5, 5)});
                acc_n++;
            end
            if (b5.out_valid && r) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_output cyc=%0d got=%h exp=none", cyc, a5);
                end else begin
                    exp_all = q.pop_front();
                    if (a5 !== exp_all[16:0] || a2 !== exp_all[33:17] || a16 !== exp_all[50:34]) begin
                        errors++; $display("FAIL rnd_result cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, a5, a2, a16,
                                           exp_all[16:0], exp_all[33:17], exp_all[50:34]);
                    end
                end
            end
            stall_prev = b5.out_valid && !r;
            h5 = a5; h2 = a2; h16 = a16;
            @(negedge clk);
            cyc++;
        end
        checks++; if (acc_n != 1000 || q.size() != 0) begin
            errors++; $display("FAIL rnd_complete got accepted=%0d pending=%0d exp 1000/0", acc_n, q.size());
        end
        idle_all();
    endtask

    task automatic test_widths();
        idle_all();
        b16.in_valid = 1'b1; b16.in_data = 16'h8000; b16.in_mode = 2'd2;
        b2.in_valid  = 1'b1; b2.in_data  = 2'b10;    b2.in_mode  = 2'd1;
        #1;
        checks++; if (b16.in_ready !== 1'b1 || b2.in_ready !== 1'b1) begin
            errors++; $display("FAIL width_accept got=%b%b exp=11", b16.in_ready, b2.in_ready);
        end
        @(negedge clk);
        b16.in_valid = 1'b0; b2.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (b16.out_valid !== 1'b1 || b16.out_data !== 16'h0000 || b16.out_err !== 1'b0) begin
            errors++; $display("FAIL w16_inc_wrap got v=%b d=%h e=%b exp v=1 d=0000 e=0", b16.out_valid, b16.out_data, b16.out_err);
        end
        checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 2'b11 || b2.out_err !== 1'b0) begin
            errors++; $display("FAIL w2_g2b got v=%b d=%b e=%b exp v=1 d=11 e=0", b2.out_valid, b2.out_data, b2.out_err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_roundtrip();
        test_backpressure();
        test_random();
        test_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "bench did not complete");
    end
endmodule
